// File: rtl/styler_pixel_seq_if.sv
// styler_pixel_seq_if: request, styler-core and pixel-stream signals of styler_pixel_seq.
// STYLER_PIXEL_SEQ_XDOUBLE_EN adds the xdouble request qualifier.
interface styler_pixel_seq_if #(
   parameter int PIX_W  = 8,
   parameter int LINE_W = 4
);
   logic              frame_start;
   logic              cell_valid;
   logic              cell_ready;
   logic [LINE_W-1:0] cell_line;
   logic [PIX_W-1:0]  row_in;
   logic [LINE_W-1:0] line_idx;
   logic              blink_phase;
   logic              cursor_phase;
   logic              faint_phase;
   logic              pix_en;
   logic              pix_out;
   logic              pix_valid;
   logic              cell_done;
`ifdef STYLER_PIXEL_SEQ_XDOUBLE_EN
   logic              xdouble;
`endif
   modport master (
      output frame_start, cell_valid, cell_line, row_in, pix_en,
`ifdef STYLER_PIXEL_SEQ_XDOUBLE_EN
      output xdouble,
`endif
      input  cell_ready, line_idx, blink_phase, cursor_phase, faint_phase, pix_out, pix_valid, cell_done
   );
   modport slave (
      input  frame_start, cell_valid, cell_line, row_in, pix_en,
`ifdef STYLER_PIXEL_SEQ_XDOUBLE_EN
      input  xdouble,
`endif
      output cell_ready, line_idx, blink_phase, cursor_phase, faint_phase, pix_out, pix_valid, cell_done
   );
endinterface

// File: rtl/styler_pixel_seq.sv
// styler_pixel_seq: scanline serialiser and blink/cursor/faint phase generator for the glyph styler core.
// Define STYLER_PIXEL_SEQ_XDOUBLE_EN to add xdouble (each pixel held for two pix_en strobes).
module styler_pixel_seq #(
   parameter int PIX_W      = 8,
   parameter int LINE_W     = 4,
   parameter int FRAME_W    = 6,
   parameter int BLINK_BIT  = 4,
   parameter int CURSOR_BIT = 3
) (
   input logic               clk,
   input logic               rst,
   styler_pixel_seq_if.slave bus
);
   localparam int CW = $clog2(PIX_W) + 1;
   localparam logic [CW-1:0] LAST1 = CW'(PIX_W - 1);
   localparam logic [CW-1:0] LAST2 = CW'(2 * PIX_W - 1);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
   state_t             state, state_n;
   logic [FRAME_W-1:0] frame_cnt;
   logic [PIX_W-1:0]   shreg;
   logic [CW-1:0]      cnt;
   logic [LINE_W-1:0]  line_idx;
   logic               blink_phase, cursor_phase, faint_phase;
   logic               pix_out, pix_valid, cell_done;
   logic               dbl, accept, strobe, last;
   assign accept = bus.cell_valid && state == IDLE;
   assign strobe = state == SHIFT && bus.pix_en;
   assign last   = cnt == (dbl ? LAST2 : LAST1);
`ifdef STYLER_PIXEL_SEQ_XDOUBLE_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) dbl <= 1'b0;
      else if (accept) dbl <= bus.xdouble;
`else
   assign dbl = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      state_n = accept          ? LOAD  :
                state == LOAD   ? SHIFT :
                strobe && last  ? IDLE  : state;
   end
   // The frame counter runs freely; cell outputs only change on accept, keeping the core coherent
   always_ff @(posedge clk or posedge rst)
      if (rst) frame_cnt <= '0;
      else if (bus.frame_start) frame_cnt <= frame_cnt + 1'b1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         line_idx     <= '0;
         blink_phase  <= 1'b0;
         cursor_phase <= 1'b0;
         faint_phase  <= 1'b0;
         shreg        <= '0;
         cnt          <= '0;
         pix_out      <= 1'b0;
         pix_valid    <= 1'b0;
         cell_done    <= 1'b0;
      end else begin
         pix_valid <= 1'b0;
         cell_done <= 1'b0;
         if (accept) begin
            line_idx     <= bus.cell_line;
            blink_phase  <= frame_cnt[BLINK_BIT];
            cursor_phase <= frame_cnt[CURSOR_BIT];
            faint_phase  <= bus.cell_line[0] ^ frame_cnt[0];
         end
         if (state == LOAD) begin
            shreg <= bus.row_in;
            cnt   <= '0;
         end
         if (strobe) begin
            pix_out   <= shreg[PIX_W-1];
            pix_valid <= 1'b1;
            cnt       <= cnt + 1'b1;
            cell_done <= last;
            if (!dbl || cnt[0]) shreg <= shreg << 1;
         end
      end
   assign bus.cell_ready   = state == IDLE;
   assign bus.line_idx     = line_idx;
   assign bus.blink_phase  = blink_phase;
   assign bus.cursor_phase = cursor_phase;
   assign bus.faint_phase  = faint_phase;
   assign bus.pix_out      = pix_out;
   assign bus.pix_valid    = pix_valid;
   assign bus.cell_done    = cell_done;
endmodule

// File: tb/tb_styler_pixel_seq.sv
// tb_styler_pixel_seq: scoreboard bench for styler_pixel_seq with a stand-in styler core.
module tb_styler_pixel_seq;
   localparam int PIX_W = 8, LINE_W = 4;
   typedef struct {
      logic [3:0] line;
      logic       b, c, f;
      int         npix, stamp;
      bit         full;
   } cell_t;
   logic clk = 1'b0, rst = 1'b1;
   styler_pixel_seq_if #(.PIX_W(PIX_W), .LINE_W(LINE_W)) bus ();
   styler_pixel_seq #(.PIX_W(PIX_W), .LINE_W(LINE_W), .FRAME_W(6), .BLINK_BIT(4), .CURSOR_BIT(3))
      dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   cell_t      cq[$];
   bit         pq[$];
   cell_t      ne;
   logic [7:0] nrow, fixed_row;
   int         fc, cyc, pc, fs_pending, pen_mode, n_checks, n_fail;
   bit         fs_rand, use_core, xd;
   function automatic logic [7:0] core(logic [3:0] l, logic b, logic c, logic f);
      return {l, l ^ {b, c, f, 1'b1}};
   endfunction
   assign bus.row_in = use_core ? core(bus.line_idx, bus.blink_phase, bus.cursor_phase, bus.faint_phase) : fixed_row;
`ifdef STYLER_PIXEL_SEQ_XDOUBLE_EN
   assign bus.xdouble = xd;
`endif
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   always @(posedge clk) cyc++;
   // Reference model: what each accepted request must produce, from the frame count the bench keeps
   always @(negedge clk) begin
      if (rst) fc = 0;
      else begin
         if (bus.cell_valid && bus.cell_ready) begin
            ne.line  = bus.cell_line;
            ne.b     = fc[4];
            ne.c     = fc[3];
            ne.f     = bus.cell_line[0] ^ fc[0];
            ne.npix  = xd ? 2 * PIX_W : PIX_W;
            ne.stamp = cyc + 1;
            ne.full  = pen_mode == 0;
            nrow = use_core ? core(ne.line, ne.b, ne.c, ne.f) : fixed_row;
            for (int i = PIX_W - 1; i >= 0; i--) repeat (xd ? 2 : 1) pq.push_back(nrow[i]);
            cq.push_back(ne);
         end
         if (bus.frame_start) fc = (fc + 1) % 64;
      end
   end
   always @(negedge clk) begin
      if (rst) begin
         pq.delete();
         cq.delete();
         pc = 0;
      end else begin
         if (bus.pix_valid) begin
            if (pq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL pixel: got pix_valid=1, expected no pixel");
            end else check("pixel", 32'(bus.pix_out), 32'(pq.pop_front()));
            if (cq.size() > 0) begin
               check("coherent_line", 32'(bus.line_idx), 32'(cq[0].line));
               check("coherent_phases", {bus.blink_phase, bus.cursor_phase, bus.faint_phase},
                     {cq[0].b, cq[0].c, cq[0].f});
               if (pc == 0 && cq[0].full) check("first_pixel_latency", cyc - cq[0].stamp, 2);
            end
            pc++;
         end
         if (bus.cell_done) begin
            if (cq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL cell_done: got pulse, expected no cell in flight");
            end else begin
               ne = cq.pop_front();
               check("done_line", 32'(bus.line_idx), 32'(ne.line));
               check("done_phases", {bus.blink_phase, bus.cursor_phase, bus.faint_phase}, {ne.b, ne.c, ne.f});
               check("done_pixel_count", pc, ne.npix);
               check("done_ready", 32'(bus.cell_ready), 1);
               if (ne.full) check("done_latency", cyc - ne.stamp, ne.npix + 1);
            end
            pc = 0;
         end
      end
   end
   initial forever begin
      @(posedge clk);
      #1;
      bus.frame_start = fs_pending > 0 || (fs_rand && $urandom_range(3) == 0);
      if (fs_pending > 0) fs_pending--;
      bus.pix_en = pen_mode == 0 ? 1'b1 : pen_mode == 1 ? ~bus.pix_en : 1'($urandom_range(1));
   end
   task automatic send(input logic [3:0] line, input bit scramble);
      int t = 0;
      bus.cell_line  = line;
      bus.cell_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.cell_ready) break;
         if (++t > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got cell_ready=0 for 200 cycles, expected 1");
            break;
         end
         if (scramble) begin
            @(posedge clk);
            #1 bus.cell_line = 4'($urandom);
         end
      end
      @(posedge clk);
      #1 bus.cell_valid = 1'b0;
   endtask
   task automatic drain();
      int t = 0;
      while (pq.size() != 0 || cq.size() != 0 || !bus.cell_ready) begin
         @(negedge clk);
         if (++t > 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pixels outstanding, expected 0", pq.size());
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic pulses(input int n);
      fs_pending = n;
      wait (fs_pending == 0);
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.frame_start = 1'b0;
      bus.cell_valid  = 1'b0;
      bus.cell_line   = '0;
      bus.pix_en      = 1'b1;
      fixed_row = 8'hA5;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_ready", 32'(bus.cell_ready), 1);
      check("reset_line", 32'(bus.line_idx), 0);
      check("reset_phases", {bus.blink_phase, bus.cursor_phase, bus.faint_phase}, 0);
      check("reset_outputs", {bus.pix_out, bus.pix_valid, bus.cell_done}, 0);
      @(posedge clk);
      #1;
      send(4'd5, 1'b0);
      check("line_after_accept", 32'(bus.line_idx), 5);
      drain();
      pen_mode = 1;
      send(4'd5, 1'b0);
      drain();
      pen_mode = 0;
      pulses(8);
      send(4'd0, 1'b0);
      check("phases_after_8", {bus.blink_phase, bus.cursor_phase, bus.faint_phase}, 3'b010);
      drain();
      pulses(8);
      send(4'd1, 1'b0);
      check("phases_after_16", {bus.blink_phase, bus.cursor_phase, bus.faint_phase}, 3'b101);
      drain();
      pulses(48);
      send(4'd0, 1'b0);
      check("phases_after_64", {bus.blink_phase, bus.cursor_phase, bus.faint_phase}, 3'b000);
      send(4'd7, 1'b0);
      fs_pending = 5;
      drain();
      send(4'd2, 1'b0);
      check("phases_after_5", {bus.blink_phase, bus.cursor_phase, bus.faint_phase}, 3'b001);
      drain();
      send(4'd3, 1'b0);
      send(4'd9, 1'b0);
      drain();
`ifdef STYLER_PIXEL_SEQ_XDOUBLE_EN
      xd = 1'b1;
      fixed_row = 8'h80;
      send(4'd4, 1'b0);
      send(4'd6, 1'b0);
      drain();
      xd = 1'b0;
      fixed_row = 8'hA5;
`endif
      send(4'd3, 1'b0);
      for (int t = 0; t < 20 && !bus.pix_valid; t++) @(negedge clk);
      check("mid_shift_seen", 32'(bus.pix_valid), 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_reset_valid", 32'(bus.pix_valid), 0);
      check("async_reset_done", 32'(bus.cell_done), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_reset_ready", 32'(bus.cell_ready), 1);
      check("post_reset_line", 32'(bus.line_idx), 0);
      check("post_reset_phases", {bus.blink_phase, bus.cursor_phase, bus.faint_phase}, 0);
      @(posedge clk);
      #1;
      use_core = 1'b1;
      fs_rand  = 1'b1;
      pen_mode = 2;
      repeat (60) begin
`ifdef STYLER_PIXEL_SEQ_XDOUBLE_EN
         xd = 1'($urandom_range(1));
`endif
         send(4'($urandom), 1'($urandom_range(1)));
         if ($urandom_range(2) == 0) drain();
      end
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected finish within 50000 cycles");
      $fatal(1);
   end
endmodule
